// File: rtl/axi_res_tbl_cam.sv
// rtl/axi_res_tbl_cam.sv - associative AXI exclusive-access reservation table
// Entries are tagged by AXI ID; check/clear and set share one arbitrated slot.
module axi_res_tbl_cam #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned N_ENTRIES      = 4,
    parameter int unsigned GRANULE_LOG2   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [AXI_ADDR_WIDTH-1:0]        check_clr_addr_i,
    input  logic [AXI_ID_WIDTH-1:0]          check_id_i,
    input  logic                             check_clr_excl_i,
    input  logic                             check_clr_req_i,
    output logic                             check_clr_gnt_o,
    output logic                             check_res_o,
    input  logic [AXI_ADDR_WIDTH-1:0]        set_addr_i,
    input  logic [AXI_ID_WIDTH-1:0]          set_id_i,
    input  logic                             set_req_i,
    output logic                             set_gnt_o,
    output logic                             evict_o,
    output logic [$clog2(N_ENTRIES+1)-1:0]   occupancy_o
);

    localparam int unsigned GW    = AXI_ADDR_WIDTH - GRANULE_LOG2;
    localparam int unsigned AGE_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned OCC_W = $clog2(N_ENTRIES + 1);
    localparam int unsigned IDX_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
    localparam logic [AGE_W-1:0] AGE_LAST =
        (TIMEOUT_CYCLES > 0) ? AGE_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic {PRIO_CHECK, PRIO_SET} prio_e;

    logic [N_ENTRIES-1:0]    valid_q, valid_d;
    logic [AXI_ID_WIDTH-1:0] id_q    [N_ENTRIES];
    logic [AXI_ID_WIDTH-1:0] id_d    [N_ENTRIES];
    logic [GW-1:0]           gaddr_q [N_ENTRIES];
    logic [GW-1:0]           gaddr_d [N_ENTRIES];
    logic [AGE_W-1:0]        age_q   [N_ENTRIES];
    logic [AGE_W-1:0]        age_d   [N_ENTRIES];
    logic [IDX_W-1:0]        victim_q, victim_d;
    logic [OCC_W-1:0]        occ_q, occ_d;
    prio_e                   prio_q, prio_d;

    logic [GW-1:0]           check_gaddr, set_gaddr;
    logic [N_ENTRIES-1:0]    gaddr_hit, res_hit, set_id_hit;
    logic                    check_gnt, set_gnt, clr, evict;
    logic [IDX_W-1:0]        tgt;

    assign check_gaddr = check_clr_addr_i[AXI_ADDR_WIDTH-1:GRANULE_LOG2];
    assign set_gaddr   = set_addr_i[AXI_ADDR_WIDTH-1:GRANULE_LOG2];

    generate
        if (GRANULE_LOG2 > 0) begin : g_low
            logic unused_low_bits;
            assign unused_low_bits = ^{check_clr_addr_i[GRANULE_LOG2-1:0],
                                       set_addr_i[GRANULE_LOG2-1:0]};
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < N_ENTRIES; i++) begin
            gaddr_hit[i]  = valid_q[i] && (gaddr_q[i] == check_gaddr);
            res_hit[i]    = gaddr_hit[i] && (id_q[i] == check_id_i);
            set_id_hit[i] = valid_q[i] && (id_q[i] == set_id_i);
        end
    end

    // Grants are gated by reset so nothing is granted while the table is held clear.
    assign check_gnt = rst_ni && check_clr_req_i && (!set_req_i || prio_q == PRIO_CHECK);
    assign set_gnt   = rst_ni && set_req_i && !check_gnt;
    assign check_res_o     = check_gnt && (|res_hit);
    assign clr             = check_gnt && !(check_clr_excl_i && !check_res_o);
    assign evict           = set_gnt && !(|set_id_hit) && (&valid_q);
    assign check_clr_gnt_o = check_gnt;
    assign set_gnt_o       = set_gnt;
    assign evict_o         = evict;
    assign occupancy_o     = occ_q;

    // Later loop assignments override earlier ones: same-ID hit beats lowest free beats victim.
    always_comb begin
        tgt = victim_q;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) tgt = IDX_W'(i);
        end
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (set_id_hit[i]) tgt = IDX_W'(i);
        end
    end

    always_comb begin
        valid_d  = valid_q;
        id_d     = id_q;
        gaddr_d  = gaddr_q;
        age_d    = age_q;
        victim_d = victim_q;
        prio_d   = prio_q;
        occ_d    = '0;

        if (check_clr_req_i && set_req_i) begin
            prio_d = (prio_q == PRIO_CHECK) ? PRIO_SET : PRIO_CHECK;
        end

        for (int i = 0; i < N_ENTRIES; i++) begin
            if (TIMEOUT_CYCLES > 0 && valid_q[i]) begin
                if (age_q[i] == AGE_LAST) valid_d[i] = 1'b0;
                else                      age_d[i]   = age_q[i] + 1'b1;
            end
            if (clr && gaddr_hit[i]) valid_d[i] = 1'b0;
        end

        // A set overrides a same-cycle expiry of the entry it lands on.
        if (set_gnt) begin
            valid_d[tgt] = 1'b1;
            id_d[tgt]    = set_id_i;
            gaddr_d[tgt] = set_gaddr;
            age_d[tgt]   = '0;
            if (evict) begin
                victim_d = (victim_q == IDX_W'(N_ENTRIES - 1)) ? '0 : victim_q + 1'b1;
            end
        end

        for (int i = 0; i < N_ENTRIES; i++) begin
            occ_d = occ_d + OCC_W'(valid_d[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q  <= '0;
            victim_q <= '0;
            occ_q    <= '0;
            prio_q   <= PRIO_CHECK;
            for (int i = 0; i < N_ENTRIES; i++) begin
                id_q[i]    <= '0;
                gaddr_q[i] <= '0;
                age_q[i]   <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            victim_q <= victim_d;
            occ_q    <= occ_d;
            prio_q   <= prio_d;
            for (int i = 0; i < N_ENTRIES; i++) begin
                id_q[i]    <= id_d[i];
                gaddr_q[i] <= gaddr_d[i];
                age_q[i]   <= age_d[i];
            end
        end
    end

endmodule

// File: tb/tb_axi_res_tbl_cam.sv
// tb/tb_axi_res_tbl_cam.sv - scoreboard bench for axi_res_tbl_cam
// Reference table keeps the grant cycle per entry; liveness is derived from elapsed time.
module tb_axi_res_tbl_cam;

    localparam int AW = 32;
    localparam int IW = 4;
    localparam int NE = 4;
    localparam int GL = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] check_clr_addr;
    logic [IW-1:0] check_id;
    logic          check_clr_excl;
    logic          check_clr_req;
    logic          check_clr_gnt;
    logic          check_res;
    logic [AW-1:0] set_addr;
    logic [IW-1:0] set_id;
    logic          set_req;
    logic          set_gnt;
    logic          evict;
    logic [2:0]    occupancy;

    always #5 clk = ~clk;

    axi_res_tbl_cam #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_ID_WIDTH   (IW),
        .N_ENTRIES      (NE),
        .GRANULE_LOG2   (GL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .check_clr_addr_i (check_clr_addr),
        .check_id_i       (check_id),
        .check_clr_excl_i (check_clr_excl),
        .check_clr_req_i  (check_clr_req),
        .check_clr_gnt_o  (check_clr_gnt),
        .check_res_o      (check_res),
        .set_addr_i       (set_addr),
        .set_id_i         (set_id),
        .set_req_i        (set_req),
        .set_gnt_o        (set_gnt),
        .evict_o          (evict),
        .occupancy_o      (occupancy)
    );

    typedef struct {
        bit is_set;
        bit res;
        bit evict;
        int occ;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    bit            m_valid [NE];
    logic [IW-1:0] m_id    [NE];
    logic [AW-GL-1:0] m_g  [NE];
    int            m_set   [NE];
    int            cyc;
    bit            m_prio_set;
    int            m_vic;

    function automatic bit alive(int i);
        return m_valid[i] && (TO == 0 || (cyc - m_set[i]) <= TO);
    endfunction

    function automatic int occ_now();
        int n = 0;
        for (int i = 0; i < NE; i++) if (alive(i)) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NE; i++) m_valid[i] = 0;
        m_prio_set = 0;
        m_vic = 0;
    endtask

    task automatic step(input bit cr, input bit ce, input logic [AW-1:0] ca, input logic [IW-1:0] cid,
                        input bit sr, input logic [AW-1:0] sa, input logic [IW-1:0] sid,
                        output bit gc, output bit gs);
        exp_t e;
        int tgt;
        logic [AW-GL-1:0] g;
        check_clr_req = cr; check_clr_excl = ce; check_clr_addr = ca; check_id = cid;
        set_req = sr; set_addr = sa; set_id = sid;
        gc = cr && (!sr || !m_prio_set);
        gs = sr && !gc;
        if (cr && sr) m_prio_set = !m_prio_set;
        e.occ = occ_now();
        e.evict = 0;
        e.res = 0;
        if (gc) begin
            g = ca[AW-1:GL];
            for (int i = 0; i < NE; i++)
                if (alive(i) && m_id[i] == cid && m_g[i] == g) e.res = 1;
            e.is_set = 0;
            exp_q.push_back(e);
            if (!(ce && !e.res))
                for (int i = 0; i < NE; i++)
                    if (alive(i) && m_g[i] == g) m_valid[i] = 0;
        end
        if (gs) begin
            tgt = -1;
            for (int i = 0; i < NE; i++) if (alive(i) && m_id[i] == sid) tgt = i;
            if (tgt < 0)
                for (int i = NE - 1; i >= 0; i--) if (!alive(i)) tgt = i;
            if (tgt < 0) begin
                tgt = m_vic;
                m_vic = (m_vic + 1) % NE;
                e.evict = 1;
            end
            m_valid[tgt] = 1;
            m_id[tgt]    = sid;
            m_g[tgt]     = sa[AW-1:GL];
            m_set[tgt]   = cyc;
            e.is_set = 1;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_set(input logic [AW-1:0] a, input logic [IW-1:0] id);
        bit gc, gs;
        step(0, 0, '0, '0, 1, a, id, gc, gs);
    endtask

    task automatic do_chk(input bit ex, input logic [AW-1:0] a, input logic [IW-1:0] id);
        bit gc, gs;
        step(1, ex, a, id, 0, '0, '0, gc, gs);
    endtask

    task automatic do_both(input logic [AW-1:0] ca, input logic [IW-1:0] cid,
                           input logic [AW-1:0] sa, input logic [IW-1:0] sid);
        bit gc, gs;
        step(1, 0, ca, cid, 1, sa, sid, gc, gs);
    endtask

    task automatic idle(input int n);
        bit gc, gs;
        for (int k = 0; k < n; k++) step(0, 0, '0, '0, 0, '0, '0, gc, gs);
    endtask

    task automatic check_reset_outputs(input string name);
        n_tests++;
        if (check_clr_gnt || set_gnt || check_res || evict || occupancy != 0) begin
            n_fail++;
            $display("FAIL %s: gnt_c=%0d gnt_s=%0d res=%0d evict=%0d occ=%0d, expected all 0",
                     name, check_clr_gnt, set_gnt, check_res, evict, occupancy);
        end
    endtask

    task automatic do_reset_mid();
        check_clr_req = 1; set_req = 1;
        rst_n = 0;
        #1;
        check_reset_outputs("mid_reset");
        model_reset();
        @(posedge clk);
        #1;
        cyc++;
        check_clr_req = 0; set_req = 0;
        rst_n = 1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (check_clr_gnt || set_gnt) begin
                n_tests++;
                if (check_clr_gnt && set_gnt) begin
                    n_fail++;
                    $display("FAIL dual_grant: both grants high at cycle %0d, expected one", cyc);
                end else if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_grant: set=%0d at cycle %0d, expected no grant", set_gnt, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (set_gnt != mon_e.is_set || check_res != mon_e.res ||
                        evict != mon_e.evict || int'(occupancy) != mon_e.occ) begin
                        n_fail++;
                        $display("FAIL grant_resp cycle %0d: got set=%0d res=%0d evict=%0d occ=%0d, expected set=%0d res=%0d evict=%0d occ=%0d",
                                 cyc, set_gnt, check_res, evict, occupancy,
                                 mon_e.is_set, mon_e.res, mon_e.evict, mon_e.occ);
                    end
                end
            end else begin
                n_tests++;
                if (check_res || evict) begin
                    n_fail++;
                    $display("FAIL idle_outputs cycle %0d: res=%0d evict=%0d, expected 0 0", cyc, check_res, evict);
                end
            end
        end
    end

    bit pc, pce, ps, gc_r, gs_r;
    logic [AW-1:0] pca, psa;
    logic [IW-1:0] pcid, psid;

    initial begin
        rst_n = 0;
        check_clr_req = 1; set_req = 1; check_clr_excl = 0;
        check_clr_addr = '0; check_id = '0; set_addr = '0; set_id = '0;
        cyc = 0;
        model_reset();
        #1;
        check_reset_outputs("reset_state");
        check_clr_req = 0; set_req = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;

        do_set(32'h1000, 3);
        do_chk(1, 32'h1008, 3);
        do_chk(0, 32'h1000, 3);

        do_set(32'h2000, 1);
        do_set(32'h2004, 2);
        do_chk(0, 32'h2000, 5);
        do_chk(1, 32'h2000, 1);

        do_set(32'h4000, 1);
        do_chk(1, 32'h3000, 1);
        do_chk(1, 32'h4000, 1);

        for (int id = 0; id < 4; id++) do_set(32'h5000 + 32'(id * 16), IW'(id));
        do_set(32'h6000, 7);
        do_set(32'h6010, 8);
        do_chk(0, 32'h6000, 7);
        idle(10);

        do_both(32'h7000, 9, 32'h7100, 10);
        do_both(32'h7000, 9, 32'h7100, 10);
        do_both(32'h7000, 9, 32'h7100, 10);
        do_chk(0, 32'h7200, 9);
        do_both(32'h7000, 9, 32'h7100, 10);
        do_both(32'h7000, 9, 32'h7100, 10);
        idle(10);

        do_set(32'h8000, 2);
        idle(7);
        do_chk(1, 32'h8000, 2);
        do_set(32'h8000, 2);
        idle(8);
        do_chk(1, 32'h8000, 2);
        do_set(32'h8000, 2);
        idle(6);
        do_set(32'h8000, 2);
        idle(7);
        do_chk(1, 32'h8000, 2);

        do_set(32'h9000, 4);
        do_set(32'h9010, 5);
        do_reset_mid();
        do_chk(0, 32'h9000, 4);

        pc = 0; ps = 0;
        for (int k = 0; k < 800; k++) begin
            if (!pc && $urandom_range(0, 2) == 0) begin
                pc = 1;
                pce = 1'($urandom_range(0, 1));
                pca = 32'h1000 + AW'($urandom_range(0, 63));
                pcid = IW'($urandom_range(0, 5));
            end
            if (!ps && $urandom_range(0, 2) == 0) begin
                ps = 1;
                psa = 32'h1000 + AW'($urandom_range(0, 63));
                psid = IW'($urandom_range(0, 5));
            end
            step(pc, pce, pca, pcid, ps, psa, psid, gc_r, gs_r);
            if (gc_r) pc = 0;
            if (gs_r) ps = 0;
            if ($urandom_range(0, 199) == 0) begin
                do_reset_mid();
                pc = 0; ps = 0;
            end
        end

        idle(3);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_grants: %0d expected grants never seen, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
